// File: rtl/stage_accumulator.sv
// Cascade stage accumulator: sums weak-classifier outputs per stage and checks them against the stage threshold.
// Optional macro STAGE_STATS_EN adds result_wc_count, the accepted-beat count for the reported window.
module stage_accumulator #(
    parameter int NUM_STAGES  = 22,
    parameter int STAGE_IDX_W = 5,
    parameter int VAL_W       = 24,
    parameter int ACC_W       = 32,
    parameter int FRAC_BITS   = 12,
    parameter int WIN_ID_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic        [WIN_ID_W-1:0]    win_id,
    input  logic                          wc_valid,
    output logic                          wc_ready,
    input  logic signed [VAL_W-1:0]       wc_value,
    input  logic                          wc_last,
    output logic        [STAGE_IDX_W-1:0] stage_num,
    input  logic signed [ACC_W-1:0]       stage_thresh,
    output logic                          abort,
    output logic                          busy,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          result_face,
    output logic        [STAGE_IDX_W-1:0] result_stage,
    output logic        [WIN_ID_W-1:0]    result_win_id
`ifdef STAGE_STATS_EN
    ,
    output logic        [15:0]            result_wc_count
`endif
);

    if (ACC_W < VAL_W || FRAC_BITS >= VAL_W || (2 ** STAGE_IDX_W) < NUM_STAGES + 1) begin : g_param_check
        $error("stage_accumulator: inconsistent parameters");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, RESULT} state_t;

    localparam logic [STAGE_IDX_W-1:0] LastStage = STAGE_IDX_W'(NUM_STAGES - 1);
    localparam logic [STAGE_IDX_W-1:0] FaceStage = STAGE_IDX_W'(NUM_STAGES);

    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W:0]     sumWide;
    logic [STAGE_IDX_W-1:0]    stageNum_q;
    logic [WIN_ID_W-1:0]       winId_q;
    logic                      wcReady_q;
    logic                      busy_q;
    logic                      abort_q;
    logic                      resValid_q;
    logic                      resFace_q;
    logic [STAGE_IDX_W-1:0]    resStage_q;

    // One extra sign bit exposes overflow; clamp instead of wrapping.
    always_comb begin
        sumWide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - VAL_W){wc_value[VAL_W-1]}}, wc_value};
        acc_d   = sumWide[ACC_W-1:0];
        if (sumWide[ACC_W] != sumWide[ACC_W-1]) begin
            acc_d = sumWide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            stageNum_q <= '0;
            winId_q    <= '0;
            wcReady_q  <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            resValid_q <= 1'b0;
            resFace_q  <= 1'b0;
            resStage_q <= '0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ACCUM;
                        winId_q    <= win_id;
                        acc_q      <= '0;
                        stageNum_q <= '0;
                        wcReady_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (wc_valid && wcReady_q) begin
                        acc_q <= acc_d;
                        if (wc_last) begin
                            state_q   <= COMPARE;
                            wcReady_q <= 1'b0;
                        end
                    end
                end
                COMPARE: begin
                    if (acc_q >= stage_thresh) begin
                        if (stageNum_q == LastStage) begin
                            state_q    <= RESULT;
                            resValid_q <= 1'b1;
                            resFace_q  <= 1'b1;
                            resStage_q <= FaceStage;
                        end else begin
                            state_q    <= ACCUM;
                            stageNum_q <= stageNum_q + STAGE_IDX_W'(1);
                            acc_q      <= '0;
                            wcReady_q  <= 1'b1;
                        end
                    end else begin
                        // Early reject: tell upstream to drop the rest of this window.
                        state_q    <= RESULT;
                        resValid_q <= 1'b1;
                        resFace_q  <= 1'b0;
                        resStage_q <= stageNum_q;
                        abort_q    <= 1'b1;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        state_q    <= IDLE;
                        resValid_q <= 1'b0;
                        stageNum_q <= '0;
                        busy_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef STAGE_STATS_EN
    logic [15:0] wcCount_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcCount_q <= '0;
        end else if (state_q == IDLE && start) begin
            wcCount_q <= '0;
        end else if (state_q == ACCUM && wc_valid && wcReady_q && wcCount_q != 16'hFFFF) begin
            wcCount_q <= wcCount_q + 16'd1;
        end
    end

    assign result_wc_count = wcCount_q;
`endif

    assign wc_ready      = wcReady_q;
    assign stage_num     = stageNum_q;
    assign abort         = abort_q;
    assign busy          = busy_q;
    assign result_valid  = resValid_q;
    assign result_face   = resFace_q;
    assign result_stage  = resStage_q;
    assign result_win_id = winId_q;

endmodule

// File: tb/tb_stage_accumulator.sv
// Directed self-checking bench for stage_accumulator (default parameters); checks
// result_wc_count as well when built with STAGE_STATS_EN.
module tb_stage_accumulator;

    localparam int NS = 22;
    localparam int SW = 5;
    localparam int VW = 24;
    localparam int AW = 32;
    localparam int WW = 16;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          start        = 1'b0;
    logic [WW-1:0] win_id       = '0;
    logic          wc_valid     = 1'b0;
    logic [VW-1:0] wc_value     = '0;
    logic          wc_last      = 1'b0;
    logic          result_ready = 1'b0;
    logic          wc_ready;
    logic [SW-1:0] stage_num;
    logic [AW-1:0] stage_thresh;
    logic          abort;
    logic          busy;
    logic          result_valid;
    logic          result_face;
    logic [SW-1:0] result_stage;
    logic [WW-1:0] result_win_id;
`ifdef STAGE_STATS_EN
    logic [15:0]   result_wc_count;
`endif

    logic [AW-1:0] threshTable [NS];
    logic [8:0]    expCtl;
    logic [21:0]   expRes;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    // Combinational threshold lookup, as the real stage table would provide.
    assign stage_thresh = (stage_num < SW'(NS)) ? threshTable[stage_num] : '0;

    stage_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .win_id       (win_id),
        .wc_valid     (wc_valid),
        .wc_ready     (wc_ready),
        .wc_value     (wc_value),
        .wc_last      (wc_last),
        .stage_num    (stage_num),
        .stage_thresh (stage_thresh),
        .abort        (abort),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_face  (result_face),
        .result_stage (result_stage),
        .result_win_id(result_win_id)
`ifdef STAGE_STATS_EN
        ,
        .result_wc_count(result_wc_count)
`endif
    );

    function automatic logic [8:0] ctl();
        return {busy, wc_ready, result_valid, abort, stage_num};
    endfunction

    function automatic logic [21:0] res();
        return {result_face, result_stage, result_win_id};
    endfunction

    task automatic startWindow(input logic [WW-1:0] id);
        start  = 1'b1;
        win_id = id;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic sendBeat(input logic [VW-1:0] v, input logic last);
        int n = 0;
        wc_valid = 1'b1;
        wc_value = v;
        wc_last  = last;
        while (!wc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wc_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: wc_ready got %b required 1", wc_ready);
        end
        @(negedge clk);
        wc_valid = 1'b0;
        wc_last  = 1'b0;
    endtask

    task automatic releaseResult();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expCtl = '0; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL reset_ctl: got %b required %b", ctl(), expCtl); end
        expRes = '0; checks++;
        if (res() !== expRes) begin errors++; $display("[TB] FAIL reset_res: got %h required %h", res(), expRes); end
        rst_n = 1'b1;
        @(negedge clk);
        expCtl = '0; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL idle_after_reset: got %b required %b", ctl(), expCtl); end
    endtask

    task automatic test_stage_pass();
        threshTable[0] = 32'd3370;
        threshTable[1] = 32'd1;
        startWindow(16'hA5A5);
        expCtl = {4'b1100, 5'd0}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL start_accept: got %b required %b", ctl(), expCtl); end
        sendBeat(24'd2000, 1'b0);
        sendBeat(24'd1370, 1'b1);
        expCtl = {4'b1000, 5'd0}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL compare_cycle: got %b required %b", ctl(), expCtl); end
        @(negedge clk);
        expCtl = {4'b1100, 5'd1}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL equal_pass: got %b required %b", ctl(), expCtl); end
        // Accumulator must restart at zero: 0 < 1 rejects at stage 1.
        sendBeat(24'd0, 1'b1);
        @(negedge clk);
        expCtl = {4'b1011, 5'd1}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL acc_cleared: got %b required %b", ctl(), expCtl); end
        expRes = {1'b0, 5'd1, 16'hA5A5}; checks++;
        if (res() !== expRes) begin errors++; $display("[TB] FAIL acc_cleared_res: got %h required %h", res(), expRes); end
        releaseResult();
        expCtl = '0; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL release_idle: got %b required %b", ctl(), expCtl); end
    endtask

    task automatic test_stage_fail();
        threshTable[0] = 32'd3370;
        startWindow(16'h1234);
        sendBeat(24'd1000, 1'b0);
        sendBeat(24'd1000, 1'b1);
        expCtl = {4'b1000, 5'd0}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL fail_latency: got %b required %b", ctl(), expCtl); end
        @(negedge clk);
        expCtl = {4'b1011, 5'd0}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL fail_abort: got %b required %b", ctl(), expCtl); end
        expRes = {1'b0, 5'd0, 16'h1234}; checks++;
        if (res() !== expRes) begin errors++; $display("[TB] FAIL fail_res: got %h required %h", res(), expRes); end
        @(negedge clk);
        expCtl = {4'b1010, 5'd0}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL abort_one_cycle: got %b required %b", ctl(), expCtl); end
        releaseResult();
    endtask

    task automatic test_all_pass();
        for (int s = 0; s < NS; s++) threshTable[s] = AW'(s * 10);
        startWindow(16'h0A0A);
        for (int s = 0; s < NS; s++) begin
            sendBeat(24'd5, 1'b0);
            sendBeat(VW'(s * 10 - 5), 1'b1);
            @(negedge clk);
            if (s < NS - 1) begin
                expCtl = {4'b1100, SW'(s + 1)}; checks++;
                if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL advance_%0d: got %b required %b", s, ctl(), expCtl); end
            end
        end
        expCtl = {4'b1010, 5'd21}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL face_ctl: got %b required %b", ctl(), expCtl); end
        expRes = {1'b1, 5'd22, 16'h0A0A}; checks++;
        if (res() !== expRes) begin errors++; $display("[TB] FAIL face_res: got %h required %h", res(), expRes); end
`ifdef STAGE_STATS_EN
        checks++;
        if (result_wc_count !== 16'd44) begin errors++; $display("[TB] FAIL face_count: got %0d required 44", result_wc_count); end
`endif
        releaseResult();
    endtask

    task automatic test_saturation();
        threshTable[0] = 32'h7FFF_FFFF;
        threshTable[1] = 32'h8000_0001;
        startWindow(16'h5A5A);
        for (int i = 0; i < 257; i++) sendBeat(24'h7F_FFFF, i == 256);
        @(negedge clk);
        expCtl = {4'b1100, 5'd1}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL sat_max: got %b required %b", ctl(), expCtl); end
        for (int i = 0; i < 257; i++) sendBeat(24'h80_0000, i == 256);
        @(negedge clk);
        expCtl = {4'b1011, 5'd1}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL sat_min: got %b required %b", ctl(), expCtl); end
        expRes = {1'b0, 5'd1, 16'h5A5A}; checks++;
        if (res() !== expRes) begin errors++; $display("[TB] FAIL sat_min_res: got %h required %h", res(), expRes); end
`ifdef STAGE_STATS_EN
        checks++;
        if (result_wc_count !== 16'd514) begin errors++; $display("[TB] FAIL sat_count: got %0d required 514", result_wc_count); end
`endif
        releaseResult();
    endtask

    task automatic test_result_hold();
        threshTable[0] = 32'd100;
        startWindow(16'h0505);
        sendBeat(24'd50, 1'b1);
        @(negedge clk);
        expCtl = {4'b1011, 5'd0}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL hold_enter: got %b required %b", ctl(), expCtl); end
        for (int i = 0; i < 5; i++) begin
            start    = 1'b1;
            win_id   = 16'hFFFF;
            wc_valid = 1'b1;
            wc_value = 24'd7;
            @(negedge clk);
            expCtl = {4'b1010, 5'd0}; checks++;
            if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL hold_ctl_%0d: got %b required %b", i, ctl(), expCtl); end
            expRes = {1'b0, 5'd0, 16'h0505}; checks++;
            if (res() !== expRes) begin errors++; $display("[TB] FAIL hold_res_%0d: got %h required %h", i, res(), expRes); end
        end
        start    = 1'b0;
        wc_valid = 1'b0;
        releaseResult();
        @(negedge clk);
        expCtl = '0; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL start_not_queued: got %b required %b", ctl(), expCtl); end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < NS; s++) threshTable[s] = '0;
        startWindow(16'h3333);
        for (int s = 0; s < 3; s++) begin
            sendBeat(24'd1, 1'b1);
            @(negedge clk);
        end
        sendBeat(24'd5, 1'b0);
        expCtl = {4'b1100, 5'd3}; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL at_stage3: got %b required %b", ctl(), expCtl); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expCtl = '0; checks++;
        if (ctl() !== expCtl) begin errors++; $display("[TB] FAIL mid_reset_ctl: got %b required %b", ctl(), expCtl); end
        expRes = '0; checks++;
        if (res() !== expRes) begin errors++; $display("[TB] FAIL mid_reset_res: got %h required %h", res(), expRes); end
    endtask

    initial begin
        for (int s = 0; s < NS; s++) threshTable[s] = '0;
        test_reset();
        test_stage_pass();
        test_stage_fail();
        test_all_pass();
        test_saturation();
        test_result_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time expired, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
